// File: rtl/ins_mem_reg_adder.sv
`default_nettype none
// ============================================================================
// Module   : ins_mem_reg_adder
// Brief    : Parallel-load instruction memory + operand register feeding a
//            grouped carry-lookahead adder (operand-fetch / add stage).
// Revision : 1.0 - initial release
// ============================================================================
module ins_mem_reg_adder #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH*DEPTH-1:0]   r_insMem,
    input  logic                     l_insMem,
    input  logic                     e_insMem,
    input  logic [31:0]              address_insMem,
    output logic [WIDTH-1:0]         q_insMem,
    input  logic [WIDTH-1:0]         r_reg,
    input  logic                     l_reg,
    input  logic                     e_reg,
    input  logic                     w_reg,
    output logic [WIDTH-1:0]         q_reg,
    input  logic                     carryin,
    output logic [WIDTH-1:0]         sum,
    output logic                     carryout,
    output logic                     overflow
);

    localparam int c_AW     = $clog2(DEPTH);
    localparam int c_GROUPS = WIDTH / 4;

    logic [WIDTH*DEPTH-1:0] r_mem_q;
    logic [WIDTH*DEPTH-1:0] w_mem_d;
    logic [WIDTH-1:0]       r_reg_q;
    logic [WIDTH-1:0]       w_reg_d;

    logic [c_AW-1:0]        w_idx;
    logic                   w_addr_unused;

    logic [WIDTH-1:0]       w_p;
    logic [WIDTH-1:0]       w_g;
    logic [WIDTH:0]         w_c;

    // Upper address bits are ignored so reads wrap modulo DEPTH.
    assign w_idx         = address_insMem[c_AW-1:0];
    assign w_addr_unused = ^address_insMem[31:c_AW];
    assign q_insMem      = r_mem_q[w_idx*WIDTH +: WIDTH];
    assign q_reg         = r_reg_q;

    always_comb begin
        w_mem_d = r_mem_q;
        if (e_insMem && l_insMem) begin
            w_mem_d = r_insMem;
        end
    end

    // Load has priority over write-back; write-back captures the pre-edge sum.
    always_comb begin
        w_reg_d = r_reg_q;
        if (e_reg) begin
            if (l_reg) begin
                w_reg_d = r_reg;
            end else if (w_reg) begin
                w_reg_d = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_q <= '0;
            r_reg_q <= '0;
        end else begin
            r_mem_q <= w_mem_d;
            r_reg_q <= w_reg_d;
        end
    end

    assign w_p    = q_insMem ^ r_reg_q;
    assign w_g    = q_insMem & r_reg_q;
    assign w_c[0] = carryin;

    // Each 4-bit group resolves its internal carries in lookahead form;
    // group carry-outs ripple into the next group.
    generate
        for (genvar gi = 0; gi < c_GROUPS; gi++) begin : g_cla
            localparam int B = gi * 4;
            assign w_c[B+1] = w_g[B]   | (w_p[B]   & w_c[B]);
            assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                            | (w_p[B+1] & w_p[B]   & w_c[B]);
            assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                            | (w_p[B+2] & w_p[B+1] & w_g[B])
                            | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
            assign w_c[B+4] = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                            | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                            | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                            | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
        end
    endgenerate

    assign sum      = w_p ^ w_c[WIDTH-1:0];
    assign carryout = w_c[WIDTH];
    assign overflow = w_c[WIDTH] ^ w_c[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_ins_mem_reg_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_mem_reg_adder
// Brief    : Directed self-checking bench for ins_mem_reg_adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_mem_reg_adder;

    localparam int c_W = 32;
    localparam int c_D = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [c_W*c_D-1:0]   r_insMem;
    logic                 l_insMem;
    logic                 e_insMem;
    logic [31:0]          address_insMem;
    logic [c_W-1:0]       q_insMem;
    logic [c_W-1:0]       r_reg;
    logic                 l_reg;
    logic                 e_reg;
    logic                 w_reg;
    logic [c_W-1:0]       q_reg;
    logic                 carryin;
    logic [c_W-1:0]       sum;
    logic                 carryout;
    logic                 overflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ins_mem_reg_adder #(.WIDTH(c_W), .DEPTH(c_D)) dut (
        .clk            (clk),
        .reset          (reset),
        .r_insMem       (r_insMem),
        .l_insMem       (l_insMem),
        .e_insMem       (e_insMem),
        .address_insMem (address_insMem),
        .q_insMem       (q_insMem),
        .r_reg          (r_reg),
        .l_reg          (l_reg),
        .e_reg          (e_reg),
        .w_reg          (w_reg),
        .q_reg          (q_reg),
        .carryin        (carryin),
        .sum            (sum),
        .carryout       (carryout),
        .overflow       (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_reg(input logic [31:0] v);
        e_reg = 1'b1; l_reg = 1'b1; w_reg = 1'b0; r_reg = v;
        tick();
        l_reg = 1'b0; e_reg = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; r_insMem = '0; l_insMem = 1'b0; e_insMem = 1'b0;
        address_insMem = '0; r_reg = '0; l_reg = 1'b0; e_reg = 1'b0;
        w_reg = 1'b0; carryin = 1'b0;

        // Reset state
        tick();
        reset = 1'b0;
        #1;
        check("rst_q_insMem", q_insMem, 32'h0);
        check("rst_q_reg",    q_reg,    32'h0);
        check("rst_sum",      sum,      32'h0);
        check("rst_carryout", {31'b0, carryout}, 32'h0);
        check("rst_overflow", {31'b0, overflow}, 32'h0);
        carryin = 1'b1;
        #1;
        check("rst_sum_cin",  sum,      32'h1);
        carryin = 1'b0;

        // Parallel load of memory and register on one edge
        r_insMem[0*32 +: 32]  = 32'h0F0F0F0E;
        r_insMem[1*32 +: 32]  = 32'hFFFFFFFF;
        r_insMem[2*32 +: 32]  = 32'h80000000;
        r_insMem[3*32 +: 32]  = 32'h7FFFFFFF;
        r_insMem[31*32 +: 32] = 32'hFC0C0C0C;
        e_insMem = 1'b1; l_insMem = 1'b1;
        e_reg = 1'b1; l_reg = 1'b1; r_reg = 32'd5;
        tick();
        e_insMem = 1'b0; l_insMem = 1'b0; e_reg = 1'b0; l_reg = 1'b0;
        #1;
        check("ld_q_insMem", q_insMem, 32'h0F0F0F0E);
        check("ld_q_reg",    q_reg,    32'h5);
        check("add0_sum",    sum,      32'h0F0F0F13);
        check("add0_co",     {31'b0, carryout}, 32'h0);
        check("add0_ov",     {31'b0, overflow}, 32'h0);

        // Full carry chain to zero
        load_reg(32'h03F3F3F4);
        address_insMem = 32'd31;
        #1;
        check("add31_sum", sum, 32'h0);
        check("add31_co",  {31'b0, carryout}, 32'h1);
        check("add31_ov",  {31'b0, overflow}, 32'h0);

        // Negative overflow
        load_reg(32'h80000000);
        address_insMem = 32'd2;
        #1;
        check("negov_sum", sum, 32'h0);
        check("negov_co",  {31'b0, carryout}, 32'h1);
        check("negov_ov",  {31'b0, overflow}, 32'h1);

        // Positive overflow, then with carry-in
        load_reg(32'h7FFFFFFF);
        address_insMem = 32'd3;
        #1;
        check("posov_sum", sum, 32'hFFFFFFFE);
        check("posov_co",  {31'b0, carryout}, 32'h0);
        check("posov_ov",  {31'b0, overflow}, 32'h1);
        carryin = 1'b1;
        #1;
        check("posov_cin_sum", sum, 32'hFFFFFFFF);
        check("posov_cin_ov",  {31'b0, overflow}, 32'h1);

        // All-ones plus carry-in ripples through every group
        load_reg(32'h0);
        address_insMem = 32'd1;
        #1;
        check("ripple_sum", sum, 32'h0);
        check("ripple_co",  {31'b0, carryout}, 32'h1);
        check("ripple_ov",  {31'b0, overflow}, 32'h0);
        carryin = 1'b0;

        // Accumulate twice: second edge must use the updated register
        load_reg(32'd5);
        address_insMem = 32'd0;
        e_reg = 1'b1; l_reg = 1'b0; w_reg = 1'b1;
        tick();
        check("acc1_q_reg", q_reg, 32'h0F0F0F13);
        tick();
        check("acc2_q_reg", q_reg, 32'h1E1E1E21);

        // Load wins over write-back
        l_reg = 1'b1; r_reg = 32'hA5A5A5A5;
        tick();
        check("ldwins_q_reg", q_reg, 32'hA5A5A5A5);

        // Enables low: state holds despite load requests
        e_reg = 1'b0; l_reg = 1'b1; w_reg = 1'b1; r_reg = 32'h0;
        e_insMem = 1'b0; l_insMem = 1'b1; r_insMem = '1;
        tick();
        check("hold_q_insMem", q_insMem, 32'h0F0F0F0E);
        check("hold_q_reg",    q_reg,    32'hA5A5A5A5);

        // Address wrap
        address_insMem = 32'h20;
        #1;
        check("wrap_0x20", q_insMem, 32'h0F0F0F0E);
        address_insMem = 32'hFFFF_FFFF;
        #1;
        check("wrap_ones", q_insMem, 32'hFC0C0C0C);

        // Reset mid-run has priority over asserted loads
        reset = 1'b1; e_insMem = 1'b1; l_insMem = 1'b1;
        e_reg = 1'b1; l_reg = 1'b1; r_reg = 32'h12345678;
        tick();
        reset = 1'b0; e_insMem = 1'b0; l_insMem = 1'b0;
        e_reg = 1'b0; l_reg = 1'b0; w_reg = 1'b0;
        #1;
        check("mrst_q_insMem31", q_insMem, 32'h0);
        address_insMem = 32'd0;
        #1;
        check("mrst_q_insMem0", q_insMem, 32'h0);
        check("mrst_q_reg",     q_reg,    32'h0);
        check("mrst_sum",       sum,      32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
